skip_counter: RTL and testbench

- Parametrised successor to the team's fixed "skip multiples of 3" counter.
- Free-running up-counter that never emits a non-zero multiple of a runtime-programmable modulus.
- Wraps to 0 past a runtime-programmable limit.
- New configuration is taken through a valid/ready handshake and applied only at a wrap boundary, so a sequence is never corrupted mid-run.
- Intended as a pattern/address generator for test sequencing and stride-skipping logic.

---
 rtl/skip_counter_pkg.sv | 15 +
 rtl/skip_counter_step.sv | 49 ++++
 rtl/skip_counter.sv | 122 ++++++++++++
 tb/tb_skip_counter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/skip_counter_pkg.sv
// Shared constants and the configuration record for the skip_counter family.
// cfg_t is sized from the default widths; the top checks that its parameters match.
package skip_counter_pkg;

   localparam int unsigned WIDTH_DEF     = 8;
   localparam int unsigned MOD_W_DEF     = 4;
   localparam int unsigned MOD_RST_DEF   = 3;
   localparam int unsigned LIMIT_RST_DEF = (2 ** WIDTH_DEF) - 2;

   typedef struct packed {
      logic [MOD_W_DEF-1:0] mod;
      logic [WIDTH_DEF-1:0] limit;
   } cfg_t;

endpackage

// File: rtl/skip_counter_step.sv
// Combinational next-state function of the skip counter.
// The residue tracks count mod act_mod incrementally, so no divider is needed.
module skip_counter_step #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned MOD_W = 4
) (
   input  logic [WIDTH-1:0] count,
   input  logic [MOD_W-1:0] res,
   input  logic [MOD_W-1:0] act_mod,
   input  logic [WIDTH-1:0] act_limit,
   output logic [WIDTH-1:0] count_nxt,
   output logic [MOD_W-1:0] res_nxt,
   output logic             skip,
   output logic             wrap
);

   logic [WIDTH:0]   cand_s;
   logic [MOD_W-1:0] res_c_s;
   logic             skip_en_s;

   // Candidate step, then wrap check against the limit in WIDTH+1 bits.
   always_comb begin
      skip_en_s = (act_mod >= MOD_W'(2));
      cand_s    = {1'b0, count} + (WIDTH+1)'(1);
      res_c_s   = '0;
      skip      = 1'b0;
      if (skip_en_s) begin
         if (res == (act_mod - MOD_W'(1))) begin
            cand_s  = {1'b0, count} + (WIDTH+1)'(2);
            res_c_s = MOD_W'(1);
            skip    = 1'b1;
         end else begin
            res_c_s = res + MOD_W'(1);
         end
      end else begin
         res_c_s = '0;
      end
      if (cand_s > {1'b0, act_limit}) begin
         count_nxt = '0;
         res_nxt   = '0;
         wrap      = 1'b1;
      end else begin
         count_nxt = cand_s[WIDTH-1:0];
         res_nxt   = res_c_s;
         wrap      = 1'b0;
      end
   end

endmodule

// File: rtl/skip_counter.sv
// Free-running counter that steps over non-zero multiples of a programmable modulus.
// New modulus/limit arrive by valid/ready and take effect only when count returns to 0.
module skip_counter
   import skip_counter_pkg::*;
#(
   parameter int unsigned WIDTH     = WIDTH_DEF,
   parameter int unsigned MOD_W     = MOD_W_DEF,
   parameter int unsigned MOD_RST   = MOD_RST_DEF,
   parameter int unsigned LIMIT_RST = (2 ** WIDTH) - 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [MOD_W-1:0] cfg_mod,
   input  logic [WIDTH-1:0] cfg_limit,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             skip,
   output logic [MOD_W-1:0] act_mod,
   output logic [WIDTH-1:0] act_limit
);

   if ((WIDTH != WIDTH_DEF) || (MOD_W != MOD_W_DEF)) begin : g_bad_width
      $error("skip_counter: WIDTH/MOD_W must match skip_counter_pkg cfg_t");
   end

   logic [WIDTH-1:0] count_q, count_d;
   logic [MOD_W-1:0] res_q, res_d;
   logic             wrap_q, wrap_d;
   logic             skip_q, skip_d;
   cfg_t             act_q, act_d;
   cfg_t             pend_q, pend_d;
   logic             pend_valid_q, pend_valid_d;
   logic             cfg_ready_q, cfg_ready_d;
   logic             apply_s;

   logic [WIDTH-1:0] stp_count_s;
   logic [MOD_W-1:0] stp_res_s;
   logic             stp_skip_s;
   logic             stp_wrap_s;

   skip_counter_step #(
      .WIDTH (WIDTH),
      .MOD_W (MOD_W)
   ) u_step (
      .count     (count_q),
      .res       (res_q),
      .act_mod   (act_q.mod),
      .act_limit (act_q.limit),
      .count_nxt (stp_count_s),
      .res_nxt   (stp_res_s),
      .skip      (stp_skip_s),
      .wrap      (stp_wrap_s)
   );

   // Count advance, config apply and config acceptance.
   always_comb begin
      count_d      = count_q;
      res_d        = res_q;
      wrap_d       = 1'b0;
      skip_d       = 1'b0;
      act_d        = act_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      if (en) begin
         count_d = stp_count_s;
         res_d   = stp_res_s;
         wrap_d  = stp_wrap_s;
         skip_d  = stp_skip_s;
      end else begin
         count_d = count_q;
         res_d   = res_q;
      end
      // Apply needs an already-held pending slot, so it never collides with acceptance.
      apply_s = pend_valid_q && (en ? stp_wrap_s : (count_q == '0));
      if (apply_s) begin
         act_d        = pend_q;
         pend_valid_d = 1'b0;
      end else if (cfg_valid && cfg_ready_q) begin
         pend_d.mod   = cfg_mod;
         pend_d.limit = cfg_limit;
         pend_valid_d = 1'b1;
      end else begin
         pend_valid_d = pend_valid_q;
      end
      cfg_ready_d = !pend_valid_d;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q      <= '0;
         res_q        <= '0;
         wrap_q       <= 1'b0;
         skip_q       <= 1'b0;
         act_q.mod    <= MOD_W'(MOD_RST);
         act_q.limit  <= WIDTH'(LIMIT_RST);
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         cfg_ready_q  <= 1'b1;
      end else begin
         count_q      <= count_d;
         res_q        <= res_d;
         wrap_q       <= wrap_d;
         skip_q       <= skip_d;
         act_q        <= act_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         cfg_ready_q  <= cfg_ready_d;
      end
   end

   assign count     = count_q;
   assign wrap      = wrap_q;
   assign skip      = skip_q;
   assign act_mod   = act_q.mod;
   assign act_limit = act_q.limit;
   assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_skip_counter.sv
// Scoreboard bench for skip_counter: the driver pushes expectations from an
// independent modulo-based model (plus hand-computed counts); a monitor pops and compares.
module tb_skip_counter;
   import skip_counter_pkg::*;

   localparam int W  = 8;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          rst, en, cfg_valid;
   logic [MW-1:0] cfg_mod;
   logic [W-1:0]  cfg_limit;
   logic          cfg_ready, wrap, skip;
   logic [W-1:0]  count;
   logic [MW-1:0] act_mod;
   logic [W-1:0]  act_limit;

   always #5 clk = ~clk;

   skip_counter dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_mod   (cfg_mod),
      .cfg_limit (cfg_limit),
      .count     (count),
      .wrap      (wrap),
      .skip      (skip),
      .act_mod   (act_mod),
      .act_limit (act_limit)
   );

   typedef struct {
      int count;
      bit wrap;
      bit skip;
      int mod;
      int limit;
      bit ready;
      bit hand;
      int hcount;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   int m_count, m_mod, m_limit, m_pmod, m_plimit;
   bit m_pv, m_wrap, m_skip;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one expectation per clock, sampled on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("count", int'(count), e.count);
            check("wrap", int'(wrap), int'(e.wrap));
            check("skip", int'(skip), int'(e.skip));
            check("act_mod", int'(act_mod), e.mod);
            check("act_limit", int'(act_limit), e.limit);
            check("cfg_ready", int'(cfg_ready), int'(e.ready));
            if (e.hand) check("hand_count", int'(count), e.hcount);
            if (count != '0) begin
               check("inv_limit", int'(count <= act_limit), 1);
               if (act_mod >= 4'd2) check("inv_mod", int'((int'(count) % int'(act_mod)) != 0), 1);
            end
         end
      end
   end

   function automatic bit will_wrap();
      int c;
      c = m_count + 1;
      if (m_mod >= 2 && (c % m_mod) == 0) c++;
      return c > m_limit;
   endfunction

   task automatic cyc(input bit r, input bit e, input bit cv, input int cm, input int cl,
                      input bit h = 1'b0, input int hc = 0);
      int cand;
      bit acc, app;
      @(negedge clk);
      #1;
      rst       = r;
      en        = e;
      cfg_valid = cv;
      cfg_mod   = MW'(cm);
      cfg_limit = W'(cl);
      m_wrap = 1'b0;
      m_skip = 1'b0;
      if (r) begin
         m_count = 0;
         m_mod   = MOD_RST_DEF;
         m_limit = LIMIT_RST_DEF;
         m_pv    = 1'b0;
      end else begin
         acc  = cv && !m_pv;
         cand = m_count;
         if (e) begin
            cand = m_count + 1;
            if (m_mod >= 2 && (cand % m_mod) == 0) begin
               cand++;
               m_skip = 1'b1;
            end
            if (cand > m_limit) begin
               cand   = 0;
               m_wrap = 1'b1;
            end
         end
         app     = m_pv && (e ? m_wrap : (m_count == 0));
         m_count = cand;
         if (app) begin
            m_mod   = m_pmod;
            m_limit = m_plimit;
            m_pv    = 1'b0;
         end
         if (acc) begin
            m_pmod   = cm;
            m_plimit = cl;
            m_pv     = 1'b1;
         end
      end
      sb.push_back('{count: m_count, wrap: m_wrap, skip: m_skip, mod: m_mod,
                     limit: m_limit, ready: !m_pv, hand: h, hcount: hc});
   endtask

   initial begin
      int hs[$];
      bit was_ready;
      rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_mod = '0; cfg_limit = '0;
      m_count = 0; m_mod = MOD_RST_DEF; m_limit = LIMIT_RST_DEF; m_pv = 1'b0;
      m_pmod = 0; m_plimit = 0;

      cyc(1, 0, 0, 0, 0, 1'b1, 0);
      cyc(1, 0, 0, 0, 0, 1'b1, 0);

      // Default modulus 3, limit 254: full run up to the wrap.
      hs = '{1, 2, 4, 5, 7, 8, 10};
      for (int i = 0; i < 171; i++) begin
         if (i < 7)         cyc(0, 1, 0, 0, 0, 1'b1, hs[i]);
         else if (i == 169) cyc(0, 1, 0, 0, 0, 1'b1, 254);
         else if (i == 170) cyc(0, 1, 0, 0, 0, 1'b1, 0);
         else               cyc(0, 1, 0, 0, 0);
      end

      // Mid-run offer waits for the wrap.
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 1, 4, 20);
      for (int k = 0; k < 300 && !m_wrap; k++) cyc(0, 1, 0, 0, 0);
      hs = '{1, 2, 3, 5, 6, 7, 9, 10, 11, 13, 14, 15, 17, 18, 19, 0};
      foreach (hs[i]) cyc(0, 1, 0, 0, 0, 1'b1, hs[i]);

      // Idle apply with skipping disabled, then modulus 2.
      cyc(0, 0, 1, 1, 5);
      cyc(0, 0, 0, 0, 0);
      hs = '{1, 2, 3, 4, 5, 0};
      foreach (hs[i]) cyc(0, 1, 0, 0, 0, 1'b1, hs[i]);
      cyc(0, 0, 1, 0, 5);
      cyc(0, 0, 0, 0, 0);
      foreach (hs[i]) cyc(0, 1, 0, 0, 0, 1'b1, hs[i]);
      cyc(0, 0, 1, 2, 9);
      cyc(0, 0, 0, 0, 0);
      hs = '{1, 3, 5, 7, 9, 0};
      foreach (hs[i]) cyc(0, 1, 0, 0, 0, 1'b1, hs[i]);

      // Back-to-back offers: the second is held until the slot frees.
      cyc(0, 1, 1, 5, 30);
      for (int k = 0; k < 60; k++) begin
         was_ready = !m_pv;
         cyc(0, 1, 1, 3, 12);
         if (was_ready) break;
      end
      for (int k = 0; k < 40; k++) cyc(0, 1, 0, 0, 0);

      // Offer in the very cycle of a wrap: applies at the following wrap.
      for (int k = 0; k < 40; k++) begin
         if (!m_pv && will_wrap()) begin
            cyc(0, 1, 1, 4, 10);
            break;
         end
         cyc(0, 1, 0, 0, 0);
      end
      for (int k = 0; k < 40; k++) cyc(0, 1, 0, 0, 0);

      // Limit 0: count pinned at 0, wrap every enabled cycle.
      for (int k = 0; k < 300 && !(m_count == 0 && !m_pv); k++) cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 3, 0);
      cyc(0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0, 1'b1, 0);

      // Random enable and offers.
      for (int k = 0; k < 1000; k++) begin
         cyc(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 60)));
      end

      // Mid-run reset with a pending config: pending is discarded.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 1, 7, 50);
      for (int k = 0; k < 200 && m_count != 100; k++) cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 1, 5, 5, 1'b1, 0);
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 1'b1, 0);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
